// File: rtl/fetch_next_pc_if.sv
// Bundle of every fetch-stage bus: I-cache, BTB, decode, redirect and training.
// Decode handshake: an instruction transfers on a cycle where if_valid and if_ready are both high;
// while if_valid is high and if_ready is low, if_pc/if_ins/if_pred_* hold their values.
interface fetch_next_pc_if;
    logic        icache_read;
    logic [31:0] icache_address;
    logic [31:0] icache_rdata;
    logic        icache_resp;
    logic        btb_read;
    logic [31:0] btb_pc;
    logic [31:0] btb_ins;
    logic [31:0] btb_target;
    logic        btb_resp;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  fsm_state;

    modport master (
        output icache_read, icache_address, btb_read, btb_pc, btb_ins,
               if_valid, if_pc, if_ins, if_pred_taken, if_pred_target, fsm_state,
        input  icache_rdata, icache_resp, btb_target, btb_resp, if_ready,
               redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken
    );

    modport slave (
        input  icache_read, icache_address, btb_read, btb_pc, btb_ins,
               if_valid, if_pc, if_ins, if_pred_taken, if_pred_target, fsm_state,
        output icache_rdata, icache_resp, btb_target, btb_resp, if_ready,
               redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Fetch stage: owns the PC, reads the I-cache, consults the BTB and a 2-bit bimodal
// table for branches/JAL, and hands one predicted instruction at a time to decode.
module fetch_next_pc #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0060,
    parameter int          BHT_IDX_BITS = 6
) (
    input logic            clk,
    input logic            rst_n,
    fetch_next_pc_if.master bus
);
    localparam int BHT_SIZE = 1 << BHT_IDX_BITS;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {FETCH = 2'd0, BTB = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        drain_btb_q, drain_btb_d;
    logic [1:0]  bht [BHT_SIZE];

    logic [31:0]             pc_plus4;
    logic [BHT_IDX_BITS-1:0] rd_idx;
    logic [BHT_IDX_BITS-1:0] up_idx;
    logic [1:0]              up_cnt;
    logic [1:0]              up_next;
    logic                    ins_is_jal;
    logic                    rdata_is_ctl;
    logic                    taken_c;

    assign pc_plus4     = pc_q + 32'd4;
    assign rd_idx       = pc_q[BHT_IDX_BITS+1:2];
    assign up_idx       = bus.upd_pc[BHT_IDX_BITS+1:2];
    assign ins_is_jal   = (ins_q[6:0] == OP_JAL);
    assign rdata_is_ctl = (bus.icache_rdata[6:0] == OP_JAL) || (bus.icache_rdata[6:0] == OP_BRANCH);
    // Reads the table before this cycle's update lands, so a same-index update is not seen yet.
    assign taken_c      = ins_is_jal | bht[rd_idx][1];

    assign up_cnt  = bht[up_idx];
    assign up_next = bus.upd_taken ? ((up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'd1)
                                   : ((up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'd1);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ins_d         = ins_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        drain_btb_d   = drain_btb_q;

        case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (bus.icache_resp) begin
                        state_d = FETCH;
                    end else begin
                        state_d     = DRAIN;
                        drain_btb_d = 1'b0;
                    end
                end else if (bus.icache_resp) begin
                    ins_d = bus.icache_rdata;
                    if (rdata_is_ctl) begin
                        state_d = BTB;
                    end else begin
                        pred_taken_d  = 1'b0;
                        pred_target_d = pc_plus4;
                        state_d       = HOLD;
                    end
                end
            end
            BTB: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (bus.btb_resp) begin
                        state_d = FETCH;
                    end else begin
                        state_d     = DRAIN;
                        drain_btb_d = 1'b1;
                    end
                end else if (bus.btb_resp) begin
                    pred_taken_d  = taken_c;
                    pred_target_d = taken_c ? bus.btb_target : pc_plus4;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = FETCH;
                end else if (bus.if_ready) begin
                    pc_d    = pred_target_q;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end
                if (drain_btb_q ? bus.btb_resp : bus.icache_resp) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            ins_q         <= 32'd0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
            drain_btb_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ins_q         <= ins_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            drain_btb_q   <= drain_btb_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            bht[up_idx] <= up_next;
        end
    end

    // The outstanding request stays asserted through DRAIN until its response returns.
    assign bus.icache_read    = (state_q == FETCH) || ((state_q == DRAIN) && !drain_btb_q);
    assign bus.icache_address = pc_q;
    assign bus.btb_read       = (state_q == BTB) || ((state_q == DRAIN) && drain_btb_q);
    assign bus.btb_pc         = pc_q;
    assign bus.btb_ins        = ins_q;
    assign bus.if_valid       = (state_q == HOLD) && !bus.redirect_valid;
    assign bus.if_pc          = pc_q;
    assign bus.if_ins         = ins_q;
    assign bus.if_pred_taken  = pred_taken_q;
    assign bus.if_pred_target = pred_target_q;
    assign bus.fsm_state      = state_q;
endmodule
